// File: rtl/instr_loader_pkg.sv
// Shared widths, state encoding and count saturation for the instruction loader.
// Pure definitions: no latency and no flow control of its own.
package instr_loader_pkg;

    localparam int NB_BYTE         = 8;
    localparam int NB_DATA         = 32;
    localparam int ADDR_WIDTH      = 7;
    localparam int BYTES_PER_INSTR = 4;
    localparam int BYTE_CNT_W      = $clog2(BYTES_PER_INSTR);
    localparam int MAX_WORDS       = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CNT = 3'd1,
        ST_RECV     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Clamp the requested word count to the imem depth so the address never wraps mid-load.
    function automatic logic [NB_BYTE-1:0] sat_count(input logic [NB_BYTE-1:0] raw);
        logic [NB_BYTE-1:0] result;
        result = raw;
        if (int'(raw) > MAX_WORDS) begin
            result = NB_BYTE'(MAX_WORDS);
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Packs 4 UART bytes big-endian into one word; o_word_valid is combinational with the 4th byte.
// No backpressure: every i_valid byte is taken; i_clear restarts word alignment.
module instr_loader_byte_assembler
    import instr_loader_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_clear,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB_DATA-1:0] o_word,
    output logic               o_word_valid
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_INSTR - 1);

    // Only the three oldest bytes need storage; the fourth is taken straight from i_byte.
    logic [NB_DATA-NB_BYTE-1:0] r_shift;
    logic [BYTE_CNT_W-1:0]      r_byte_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_clear) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (i_valid) begin
            r_shift    <= {r_shift[NB_DATA-2*NB_BYTE-1:0], i_byte};
            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        end
    end

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_valid && !i_clear && (r_byte_cnt == LAST_BYTE);

endmodule

// File: rtl/instr_loader.sv
// Loads a UART byte stream into imem: count byte, then 4-byte words at addresses 0..count-1.
// Write strobe one cycle after each word's 4th byte; no backpressure, imem must accept every strobe.
module instr_loader
    import instr_loader_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_rx_done,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    output logic [NB_DATA-1:0]    o_inst_load,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic                  o_en_write,
    output logic                  o_busy,
    output logic [NB_BYTE-1:0]    o_inst_count,
    output logic                  o_load_done
);

    state_t                r_state;
    logic [NB_BYTE-1:0]    r_inst_count;
    logic [NB_BYTE-1:0]    r_words;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [NB_DATA-1:0]    r_inst_load;
    logic                  r_en_write;
    logic                  r_busy;
    logic                  r_load_done;

    logic                  w_asm_valid;
    logic                  w_asm_clear;
    logic                  w_word_valid;
    logic [NB_DATA-1:0]    w_word;
    logic [NB_BYTE-1:0]    w_words_next;

    // A byte landing in the WRITE cycle already belongs to the next word.
    assign w_asm_valid  = i_rx_done && ((r_state == ST_RECV) || (r_state == ST_WRITE));
    assign w_asm_clear  = i_rx_done && (r_state == ST_WAIT_CNT);
    assign w_words_next = r_words + NB_BYTE'(1);

    instr_loader_byte_assembler u_byte_assembler (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (w_asm_valid),
        .i_clear      (w_asm_clear),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_inst_count <= '0;
            r_words      <= '0;
            r_address    <= '0;
            r_inst_load  <= '0;
            r_en_write   <= 1'b0;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_en_write  <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_WAIT_CNT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_CNT: begin
                    if (i_rx_done) begin
                        r_inst_count <= sat_count(i_rx_data);
                        r_words      <= '0;
                        r_address    <= '0;
                        if (i_rx_data == '0) begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (w_word_valid) begin
                        r_inst_load <= w_word;
                        r_en_write  <= 1'b1;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_address <= r_address + ADDR_WIDTH'(1);
                    r_words   <= w_words_next;
                    if (w_words_next == r_inst_count) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_load_done <= 1'b1;
                    end else begin
                        r_state <= ST_RECV;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_inst_load  = r_inst_load;
    assign o_address    = r_address;
    assign o_en_write   = r_en_write;
    assign o_busy       = r_busy;
    assign o_inst_count = r_inst_count;
    assign o_load_done  = r_load_done;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: expected writes and done timing come from a byte-stream model.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [31:0] inst_load;
    logic [6:0]  addr;
    logic        en_write;
    logic        busy;
    logic [7:0]  inst_count;
    logic        load_done;

    instr_loader dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .o_inst_load  (inst_load),
        .o_address    (addr),
        .o_en_write   (en_write),
        .o_busy       (busy),
        .o_inst_count (inst_count),
        .o_load_done  (load_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        act_w[$];
    int         act_done[$];
    logic [7:0] byte_val[$];
    int         byte_cyc[$];
    logic [7:0] dir[$];
    int         cnt_cyc;

    always @(negedge clk) begin
        wr_t w;
        if (en_write) begin
            w.addr = int'(addr);
            w.data = inst_load;
            w.cyc  = cyc;
            act_w.push_back(w);
        end
        if (load_done) act_done.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit rec);
        rx_done = 1'b1;
        rx_data = b;
        if (rec) begin
            byte_val.push_back(b);
            byte_cyc.push_back(cyc);
        end
        tick();
        rx_done = 1'b0;
        start   = 1'b0;
        rx_data = 8'($urandom);
        repeat (gap) tick();
    endtask

    // Model: n = min(count,128); word k = bytes 4k..4k+3 big-endian at addr k,
    // strobed the cycle after its 4th byte; done one cycle after the last strobe.
    task automatic run_load(input string name, input logic [7:0] cnt, input int nbytes,
                            input int gap_max, input int pre, input int stray_at);
        int          n;
        int          exp_done;
        logic [31:0] w;
        act_w.delete();
        act_done.delete();
        byte_val.delete();
        byte_cyc.delete();
        for (int i = 0; i < pre; i++) send(8'($urandom), int'($urandom_range(0, 1)), 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt_cyc = cyc;
        send(cnt, int'($urandom_range(0, gap_max)), 1'b0);
        if (cnt != 8'd0) check({name, ".busy_mid"}, 64'(busy), 64'(1));
        for (int i = 0; i < nbytes; i++) begin
            if (i == stray_at) start = 1'b1;
            send((dir.size() > i) ? dir[i] : 8'($urandom), int'($urandom_range(0, gap_max)), 1'b1);
        end
        repeat (6) tick();

        n = (cnt > 8'd128) ? 128 : int'(cnt);
        check({name, ".nwrites"}, 64'(act_w.size()), 64'(n));
        for (int k = 0; k < n && k < act_w.size(); k++) begin
            w = {byte_val[4*k], byte_val[4*k+1], byte_val[4*k+2], byte_val[4*k+3]};
            check($sformatf("%s.addr%0d", name, k), 64'(act_w[k].addr), 64'(k));
            check($sformatf("%s.data%0d", name, k), 64'(act_w[k].data), 64'(w));
            check($sformatf("%s.wcyc%0d", name, k), 64'(act_w[k].cyc), 64'(byte_cyc[4*k+3] + 1));
        end
        exp_done = (n == 0) ? cnt_cyc + 1 : byte_cyc[4*n-1] + 2;
        check({name, ".ndone"}, 64'(act_done.size()), 64'(1));
        if (act_done.size() > 0) check({name, ".done_cyc"}, 64'(act_done[0]), 64'(exp_done));
        check({name, ".count"}, 64'(inst_count), 64'(n));
        check({name, ".busy_end"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [7:0] c;
        rst     = 1'b1;
        start   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        #1;
        check("reset.outputs", 64'({inst_load, addr, en_write, busy, inst_count, load_done}), 64'(0));
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a word aborts the load.
        act_w.delete();
        act_done.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'd3, 0, 1'b0);
        send(8'hA1, 0, 1'b0);
        send(8'hA2, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("midreset.outputs", 64'({inst_load, addr, en_write, busy, inst_count, load_done}), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) send(8'($urandom), 0, 1'b0);
        repeat (4) tick();
        check("midreset.nwrites", 64'(act_w.size()), 64'(0));
        check("midreset.ndone", 64'(act_done.size()), 64'(0));

        dir = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        run_load("two_words", 8'h02, 8, 0, 0, -1);
        check("two_words.w0", 64'(act_w.size() > 0 ? act_w[0].data : 32'h0), 64'(32'h02030405));
        check("two_words.w1", 64'(act_w.size() > 1 ? act_w[1].data : 32'h0), 64'(32'h06070809));

        dir = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load("write_cycle_byte", 8'h02, 8, 0, 0, -1);
        check("write_cycle_byte.w1", 64'(act_w.size() > 1 ? act_w[1].data : 32'h0), 64'(32'hAABBCCDD));
        dir.delete();

        run_load("zero_count", 8'h00, 0, 1, 0, -1);
        run_load("stray", 8'h03, 12, 2, 3, 6);
        run_load("exact128", 8'd128, 512, 0, 0, -1);
        run_load("sat_ff", 8'hFF, 520, 1, 0, -1);

        for (int r = 0; r < 6; r++) begin
            c = 8'($urandom_range(1, 20));
            run_load($sformatf("rnd%0d", r), c, 4 * int'(c) + int'($urandom_range(0, 5)), 2, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
